// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM with retired-instruction counter and illegal-opcode trap
module multicycle_control (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        ALUSrcA,
    output logic        RegWrite,
    output logic        RegDst,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [2:0]  ula_operation,
    output logic [1:0]  BranchOp,
    output logic [3:0]  state,
    output logic [31:0] instr_count,
    output logic        trap
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        EXEC_I   = 4'd10,
        I_WB     = 4'd11,
        TRAP     = 4'd15
    } state_t;

    state_t      state_q;
    logic [31:0] count_q;

    assign state       = state_q;
    assign instr_count = count_q;

    // Next-state sequencing; the count bumps only on a retiring return to FETCH
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= FETCH;
            count_q <= '0;
        end else begin
            case (state_q)
                FETCH:    if (mem_ready) state_q <= DECODE;
                DECODE: begin
                    case (opcode)
                        6'h00:        state_q <= EXEC_R;
                        6'h23, 6'h2B: state_q <= MEM_ADDR;
                        6'h04, 6'h05: state_q <= BRANCH;
                        6'h02:        state_q <= JUMP;
                        6'h08, 6'h0A: state_q <= EXEC_I;
                        default:      state_q <= TRAP;
                    endcase
                end
                MEM_ADDR: state_q <= (opcode == 6'h23) ? MEM_RD : MEM_WR;
                MEM_RD:   if (mem_ready) state_q <= MEM_WB;
                MEM_WR: begin
                    if (mem_ready) begin
                        state_q <= FETCH;
                        count_q <= count_q + 32'd1;
                    end
                end
                EXEC_R:   state_q <= R_WB;
                EXEC_I:   state_q <= I_WB;
                MEM_WB, R_WB, BRANCH, JUMP, I_WB: begin
                    state_q <= FETCH;
                    count_q <= count_q + 32'd1;
                end
                TRAP:     state_q <= TRAP;
                default:  state_q <= TRAP;
            endcase
        end
    end

    // Moore decode of datapath controls; only FETCH's write strobes follow mem_ready
    always_comb begin
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        ALUSrcA       = 1'b0;
        RegWrite      = 1'b0;
        RegDst        = 1'b0;
        ALUSrcB       = 2'b00;
        PCSource      = 2'b00;
        ula_operation = 3'b000;
        BranchOp      = 2'b00;
        trap          = 1'b0;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE:   ALUSrcB = 2'b11;
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXEC_R: begin
                ALUSrcA       = 1'b1;
                ula_operation = 3'b010;
            end
            R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA       = 1'b1;
                ula_operation = 3'b001;
                PCWriteCond   = 1'b1;
                PCSource      = 2'b01;
                if (opcode == 6'h04)      BranchOp = 2'b01;
                else if (opcode == 6'h05) BranchOp = 2'b10;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            EXEC_I: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'b10;
                ula_operation = (opcode == 6'h0A) ? 3'b101 : 3'b000;
            end
            I_WB:     RegWrite = 1'b1;
            TRAP:     trap = 1'b1;
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed bench with instruction-level reference model for multicycle_control
module tb_multicycle_control;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3,
                           S_MEM_WB = 4'd4, S_MEM_WR = 4'd5, S_EXEC_R = 4'd6, S_R_WB = 4'd7,
                           S_BRANCH = 4'd8, S_JUMP = 4'd9, S_EXEC_I = 4'd10, S_I_WB = 4'd11,
                           S_TRAP = 4'd15;

    logic        clock;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, ALUSrcA, RegWrite, RegDst;
    logic [1:0]  ALUSrcB, PCSource, BranchOp;
    logic [2:0]  ula_operation;
    logic [3:0]  state;
    logic [31:0] instr_count;
    logic        trap;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        exp_valid = 1'b0;
    logic [3:0]  exp_state = 4'd0;
    logic [31:0] exp_count = 32'd0;
    int          mw_cycles = 0;

    multicycle_control dut (
        .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ula_operation(ula_operation), .BranchOp(BranchOp), .state(state),
        .instr_count(instr_count), .trap(trap)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Control table from the instruction-step descriptions:
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,ALUSrcA,RegWrite,RegDst,ALUSrcB,PCSource,ula,BranchOp,trap}
    function automatic logic [19:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op, input logic mr);
        case (st)
            S_FETCH:    return {mr, 1'b0, 1'b0, 1'b1, 1'b0, mr, 4'b0000, 2'b01, 2'b00, 3'b000, 2'b00, 1'b0};
            S_DECODE:   return {10'b0, 2'b11, 2'b00, 3'b000, 2'b00, 1'b0};
            S_MEM_ADDR: return {10'b00000_00100, 2'b10, 2'b00, 3'b000, 2'b00, 1'b0};
            S_MEM_RD:   return {10'b00110_00000, 10'b0};
            S_MEM_WB:   return {10'b00000_01010, 10'b0};
            S_MEM_WR:   return {10'b00101_00000, 10'b0};
            S_EXEC_R:   return {10'b00000_00100, 2'b00, 2'b00, 3'b010, 2'b00, 1'b0};
            S_R_WB:     return {10'b00000_00011, 10'b0};
            S_BRANCH:   return {10'b01000_00100, 2'b00, 2'b01, 3'b001,
                                (op == 6'h04) ? 2'b01 : (op == 6'h05) ? 2'b10 : 2'b00, 1'b0};
            S_JUMP:     return {10'b10000_00000, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0};
            S_EXEC_I:   return {10'b00000_00100, 2'b10, 2'b00, (op == 6'h0A) ? 3'b101 : 3'b000, 2'b00, 1'b0};
            S_I_WB:     return {10'b00000_00010, 10'b0};
            S_TRAP:     return {19'b0, 1'b1};
            default:    return 20'b0;
        endcase
    endfunction

    wire [19:0] ctrl_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA,
                            RegWrite, RegDst, ALUSrcB, PCSource, ula_operation, BranchOp, trap};

    // Every checked cycle: compare state, controls and count against the model
    always @(negedge clock) begin
        if (exp_valid) begin
            check("state", {28'd0, state}, {28'd0, exp_state});
            check("controls", {12'd0, ctrl_vec}, {12'd0, exp_ctrl(exp_state, opcode, mem_ready)});
            check("instr_count", instr_count, exp_count);
            if (MemWrite === 1'b1) mw_cycles++;
        end
    end

    // One clock of stimulus; st is the state the DUT must occupy during this cycle
    task automatic cyc(input logic rst, input logic [5:0] op, input logic mr,
                       input logic [3:0] st, input logic chk, input logic ret);
        reset     = rst;
        opcode    = op;
        mem_ready = mr;
        exp_state = st;
        exp_valid = chk;
        @(posedge clock);
        if (!rst)     exp_count = 32'd0;
        else if (ret) exp_count = exp_count + 32'd1;
        #2;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 6'($urandom_range(0, 63)), rnd(), S_FETCH, 1'b0, 1'b0);
    endtask

    // Expected step sequence of one instruction, with fw fetch waits and mw memory waits
    task automatic do_instr(input logic [5:0] op, input int fw, input int mw);
        logic [3:0] mst;
        for (int i = 0; i < fw; i++) cyc(1'b1, 6'($urandom_range(0, 63)), 1'b0, S_FETCH, 1'b1, 1'b0);
        cyc(1'b1, op, 1'b1, S_FETCH, 1'b1, 1'b0);
        cyc(1'b1, op, rnd(), S_DECODE, 1'b1, 1'b0);
        if (op == 6'h23 || op == 6'h2B) begin
            cyc(1'b1, op, rnd(), S_MEM_ADDR, 1'b1, 1'b0);
            mst = (op == 6'h23) ? S_MEM_RD : S_MEM_WR;
            for (int i = 0; i < mw; i++) cyc(1'b1, op, 1'b0, mst, 1'b1, 1'b0);
            if (op == 6'h23) begin
                cyc(1'b1, op, 1'b1, S_MEM_RD, 1'b1, 1'b0);
                cyc(1'b1, op, rnd(), S_MEM_WB, 1'b1, 1'b1);
            end else begin
                cyc(1'b1, op, 1'b1, S_MEM_WR, 1'b1, 1'b1);
            end
        end else if (op == 6'h00) begin
            cyc(1'b1, op, rnd(), S_EXEC_R, 1'b1, 1'b0);
            cyc(1'b1, op, rnd(), S_R_WB, 1'b1, 1'b1);
        end else if (op == 6'h08 || op == 6'h0A) begin
            cyc(1'b1, op, rnd(), S_EXEC_I, 1'b1, 1'b0);
            cyc(1'b1, op, rnd(), S_I_WB, 1'b1, 1'b1);
        end else if (op == 6'h04 || op == 6'h05) begin
            cyc(1'b1, op, rnd(), S_BRANCH, 1'b1, 1'b1);
        end else if (op == 6'h02) begin
            cyc(1'b1, op, rnd(), S_JUMP, 1'b1, 1'b1);
        end
    endtask

    initial begin
        reset = 1'b0;
        opcode = 6'h00;
        mem_ready = 1'b0;
        @(posedge clock);
        #2;

        // Reset release shows FETCH outputs
        do_reset(2);
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'h23;
        #1;
        check("rst_state", {28'd0, state}, 32'd0);
        check("rst_memread", {31'd0, MemRead}, 32'd1);
        check("rst_irwrite", {31'd0, IRWrite}, 32'd1);
        check("rst_pcwrite", {31'd0, PCWrite}, 32'd1);
        check("rst_count", instr_count, 32'd0);

        // lw with no waits: five cycles, one retirement
        do_instr(6'h23, 0, 0);
        check("lw_count", instr_count, 32'd1);
        check("lw_back_to_fetch", {28'd0, state}, 32'd0);

        // sw with three memory waits
        do_reset(1);
        mw_cycles = 0;
        do_instr(6'h2B, 0, 3);
        check("sw_memwrite_cycles", mw_cycles, 32'd4);
        check("sw_count", instr_count, 32'd1);

        // Mixed traffic including fetch and read waits
        do_instr(6'h00, 2, 0);
        do_instr(6'h08, 0, 0);
        do_instr(6'h0A, 1, 0);
        do_instr(6'h04, 0, 0);
        do_instr(6'h23, 1, 2);
        do_instr(6'h02, 0, 0);
        check("mix_count", instr_count, 32'd7);

        // bne: inspect BRANCH outputs directly
        do_reset(1);
        cyc(1'b1, 6'h05, 1'b1, S_FETCH, 1'b1, 1'b0);
        cyc(1'b1, 6'h05, 1'b0, S_DECODE, 1'b1, 1'b0);
        opcode = 6'h05; mem_ready = 1'b0;
        #1;
        check("bne_state", {28'd0, state}, 32'd8);
        check("bne_branchop", {30'd0, BranchOp}, 32'd2);
        check("bne_pcwritecond", {31'd0, PCWriteCond}, 32'd1);
        check("bne_ula", {29'd0, ula_operation}, 32'd1);
        cyc(1'b1, 6'h05, 1'b0, S_BRANCH, 1'b1, 1'b1);
        check("bne_count", instr_count, 32'd1);

        // Counter wrap: preload one below all-ones, then two jumps
        force dut.count_q = 32'hFFFF_FFFE;
        exp_count = 32'hFFFF_FFFE;
        #1;
        release dut.count_q;
        do_instr(6'h02, 0, 0);
        check("wrap_ones", instr_count, 32'hFFFF_FFFF);
        do_instr(6'h02, 0, 0);
        check("wrap_zero", instr_count, 32'd0);

        // Abort a lw stalled in MEM_RD
        do_instr(6'h08, 0, 0);
        cyc(1'b1, 6'h23, 1'b1, S_FETCH, 1'b1, 1'b0);
        cyc(1'b1, 6'h23, 1'b1, S_DECODE, 1'b1, 1'b0);
        cyc(1'b1, 6'h23, 1'b1, S_MEM_ADDR, 1'b1, 1'b0);
        cyc(1'b1, 6'h23, 1'b0, S_MEM_RD, 1'b1, 1'b0);
        cyc(1'b1, 6'h23, 1'b0, S_MEM_RD, 1'b1, 1'b0);
        check("abort_pre_count", instr_count, 32'd1);
        do_reset(1);
        check("abort_state", {28'd0, state}, 32'd0);
        check("abort_count", instr_count, 32'd0);

        // Illegal opcode traps and holds regardless of mem_ready
        do_instr(6'h3F, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 6'h3F, 1'(i % 2), S_TRAP, 1'b1, 1'b0);
        check("trap_state", {28'd0, state}, 32'd15);
        check("trap_flag", {31'd0, trap}, 32'd1);
        check("trap_count", instr_count, 32'd0);
        do_reset(1);
        check("trap_rst_state", {28'd0, state}, 32'd0);
        check("trap_rst_flag", {31'd0, trap}, 32'd0);
        do_instr(6'h00, 0, 0);

        exp_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
